// File: rtl/alu_muldiv.sv
// ALU with single-cycle integer ops plus iterative shift-add multiply and
// restoring divide; one operation in flight, results held until the next pulse.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_XOR    = 5'b00111;
  localparam logic [4:0] OP_SRA    = 5'b01000;
  localparam logic [4:0] OP_SRL    = 5'b01001;
  localparam logic [4:0] OP_SLL    = 5'b01010;
  localparam logic [4:0] OP_SLTU   = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, d_q, d_d, a_q, a_d;
  logic [4:0]       op_q, op_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     shamt;
  logic               is_multi, is_mul, a_signed, b_signed, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, done_res;

  always_comb begin
    shamt   = SrcB[SHW-1:0];
    alu_res = '0;
    case (ALUControl)
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_XOR:  alu_res = SrcA ^ SrcB;
      OP_SRA:  alu_res = $signed(SrcA) >>> shamt;
      OP_SRL:  alu_res = SrcA >> shamt;
      OP_SLL:  alu_res = SrcA << shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes and sign flags captured at acceptance of a mul/div
  always_comb begin
    is_multi = ALUControl[4] & ~ALUControl[3];
    is_mul   = is_multi & ~ALUControl[2];
    a_signed = (ALUControl == OP_MULH) || (ALUControl == OP_MULHSU) ||
               (ALUControl == OP_DIV)  || (ALUControl == OP_REM);
    b_signed = (ALUControl == OP_MULH) || (ALUControl == OP_DIV) ||
               (ALUControl == OP_REM);
    a_neg_in = a_signed & SrcA[WIDTH-1];
    b_neg_in = b_signed & SrcB[WIDTH-1];
    a_mag    = a_neg_in ? (~SrcA + 1'b1) : SrcA;
    b_mag    = b_neg_in ? (~SrcB + 1'b1) : SrcB;
  end

  // hi/lo form the product {hi,lo} when multiplying, {remainder,dividend/quotient} when dividing
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? d_q : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d_q};
    div_ge    = ~div_diff[WIDTH];
  end

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
    quo_s  = (a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q;
    rem_s  = a_neg_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      OP_MUL:                        done_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  done_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               done_res = b_zero_q ? {WIDTH{1'b1}} : quo_s;
      OP_REM, OP_REMU:               done_res = b_zero_q ? a_q : rem_s;
      default:                       done_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    d_d         = d_q;
    a_d         = a_q;
    op_d        = op_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    b_zero_d    = b_zero_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALUControl;
          if (is_multi) begin
            a_d      = SrcA;
            a_neg_d  = a_neg_in;
            b_neg_d  = b_neg_in;
            b_zero_d = (SrcB == '0);
            hi_d     = '0;
            lo_d     = is_mul ? b_mag : a_mag;
            d_d      = is_mul ? a_mag : b_mag;
            cnt_d    = '0;
            state_d  = is_mul ? MUL : DIV;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DIV: begin
        hi_d  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        result_d    = done_res;
        zero_d      = (done_res == '0);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      d_q         <= '0;
      a_q         <= '0;
      op_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      d_q         <= d_d;
      a_q         <= a_d;
      op_q        <= op_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      b_zero_q    <= b_zero_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = ~busy;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, sets the datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), sets the shift-amount width; it is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented this cycle.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B.
REQ-009 ALUControl  input  5  opcode.
REQ-010 ALUResult  output  WIDTH  registered result.
REQ-011 Zero  output  1  registered; high when ALUResult is 0.
REQ-012 out_valid  output  1  one-cycle pulse; ALUResult and Zero are valid.
REQ-013 busy  output  1  multi-cycle operation in progress.

Function
REQ-014 An operation SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL equal NOT busy.
REQ-016 Single-cycle opcodes SHALL be as follows:
- 00000 add; 00001 sub; 00010 and; 00011 or.
- 00101 slt (signed): result 1 or 0.
- 00111 xor.
- 01000 sra; 01001 srl; 01010 sll; shifts use SrcB[SHW-1:0].
- 01011 sltu (unsigned): result 1 or 0.
REQ-017 Multi-cycle opcodes SHALL be:
- 10000 mul: low WIDTH bits of the product.
- 10001 mulh: high WIDTH bits, signed x signed.
- 10010 mulhsu: high WIDTH bits, signed A x unsigned B.
- 10011 mulhu: high WIDTH bits, unsigned x unsigned.
- 10100 div; 10101 divu; 10110 rem; 10111 remu.
REQ-018 Any other opcode SHALL complete as a single-cycle operation with ALUResult=0 and Zero=1.
REQ-019 A single-cycle operation SHALL have latency 1: accepted at edge N, out_valid=1 in the cycle after edge N.
REQ-020 The state machine SHALL have states IDLE, MUL, DIV and DONE.
- IDLE->MUL or IDLE->DIV on acceptance of a multi-cycle opcode.
- MUL/DIV->DONE after exactly WIDTH iteration cycles.
- DONE->IDLE unconditionally.
REQ-021 busy SHALL be 1 in the MUL, DIV and DONE states.
REQ-022 A multi-cycle operation SHALL raise out_valid for exactly one cycle, WIDTH+2 cycles after acceptance.
REQ-023 in_ready SHALL be 1 in the same cycle as that out_valid pulse.
REQ-024 The multiplier SHALL use shift-add, one bit per cycle, on magnitudes; the sign SHALL be corrected in DONE.
REQ-025 The divider SHALL use restoring division, one bit per cycle, on magnitudes.
REQ-026 Divider signs SHALL follow these rules:
- quotient is negative when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-027 Divide by zero SHALL return all ones for div and divu, and SrcA for rem and remu.
REQ-028 Signed overflow (SrcA = minimum signed value, SrcB = -1) SHALL return the minimum signed value for div and 0 for rem.
REQ-029 Divide by zero and signed overflow SHALL still take the full WIDTH+2 latency.
REQ-030 Operands SHALL be captured at acceptance; input changes while busy SHALL have no effect.
REQ-031 in_valid while busy SHALL be ignored; the operation is not queued.
REQ-032 ALUResult and Zero SHALL hold their value until the next out_valid pulse.
REQ-033 All arithmetic SHALL wrap modulo 2^WIDTH; no output signals overflow or carry.

Reset
REQ-034 On a clock edge with reset=1, the state SHALL go to IDLE and the outputs SHALL be ALUResult=0, Zero=1, out_valid=0, busy=0, in_ready=1.
REQ-035 A reset during MUL, DIV or DONE SHALL abort the operation with no out_valid pulse; an operation may be accepted in the first cycle after reset deasserts.
REQ-036 Reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-037 The bench SHALL cover the following directed scenarios (WIDTH=32):
- add 0x7FFFFFFF+1 -> 0x80000000, out_valid one cycle after acceptance; sub 5-5 -> 0, Zero=1.
- slt 0xFFFFFFFF,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; sra 0x80000000 by 4 -> 0xF8000000.
- mulh 0xFFFFFFFF x 0xFFFFFFFF -> 0; mulhu of the same -> 0xFFFFFFFE; mul 7 x -3 -> 0xFFFFFFEB; out_valid exactly 34 cycles after acceptance.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 7/0 -> 0xFFFFFFFF; remu 7/0 -> 7; div 0x80000000/-1 -> 0x80000000 with rem 0.
- in_valid held high with changing operands during a div -> no second out_valid, and the result matches the captured operands.
- reset asserted 10 cycles into a mul -> no out_valid, outputs at reset values; an add accepted the next cycle completes normally.
- Repeat the mul/div checks at WIDTH=8 against a reference model: latency 10, 8-bit results.
